// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, runs one outstanding imem request at a time,
// resolves execute redirects and hands a single buffered instruction to decode.
module fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'('h1000)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redir_valid,
  input  logic [2:0]         redir_src,
  input  logic [ADDR_W-1:0]  redir_tar,
  input  logic [ADDR_W-1:0]  redir_alu,
  input  logic               redir_zero,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               if_ready,
  output logic               err_src
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic               stale, stale_nxt;
  logic               run;
  logic               vld_nxt;
  logic [INSTR_W-1:0] instr_nxt;
  logic [ADDR_W-1:0]  ifpc_nxt;
  logic               taken, src_bad;
  logic [ADDR_W-1:0]  target;

  always_comb begin
    taken  = 1'b0;
    target = redir_tar;
    if (redir_valid) begin
      case (redir_src)
        3'b001:  taken = redir_zero;
        3'b010:  taken = !redir_zero;
        3'b011:  taken = 1'b1;
        3'b100:  begin taken = 1'b1; target = redir_alu; end
        default: taken = 1'b0;
      endcase
    end
    src_bad = redir_valid && (redir_src > 3'b100);
  end

  // run holds off the first request until the cycle after reset release
  assign imem_req  = run && (state == S_REQ);
  assign imem_addr = pc;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    stale_nxt = stale;
    vld_nxt   = if_valid;
    instr_nxt = if_instr;
    ifpc_nxt  = if_pc;
    case (state)
      S_REQ: begin
        if (imem_req && imem_gnt) begin
          state_nxt = S_WAIT;
          pc_nxt    = pc + ADDR_W'(4);
        end
        if (taken) begin
          pc_nxt = target;
          if (imem_req && imem_gnt) stale_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (taken) begin
          pc_nxt = target;
          // a same-cycle response is the old-path data itself, so nothing is left in flight
          if (imem_rvalid) begin
            stale_nxt = 1'b0;
            state_nxt = S_REQ;
          end else begin
            stale_nxt = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (stale) begin
            stale_nxt = 1'b0;
            state_nxt = S_REQ;
          end else begin
            instr_nxt = imem_rdata;
            ifpc_nxt  = pc - ADDR_W'(4);
            vld_nxt   = 1'b1;
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (taken) begin
          vld_nxt   = 1'b0;
          pc_nxt    = target;
          state_nxt = S_REQ;
        end else if (if_ready) begin
          vld_nxt   = 1'b0;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      stale    <= 1'b0;
      run      <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
      err_src  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      stale    <= stale_nxt;
      run      <= 1'b1;
      if_valid <= vld_nxt;
      if_instr <= instr_nxt;
      if_pc    <= ifpc_nxt;
      if (src_bad) err_src <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a bench-side imem responder plus queues of expected
// decode PCs and expected granted addresses.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        redir_valid, redir_zero;
  logic [2:0]  redir_src;
  logic [31:0] redir_tar, redir_alu;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, if_ready, err_src;
  logic [31:0] if_instr, if_pc;

  fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .redir_valid(redir_valid), .redir_src(redir_src), .redir_tar(redir_tar),
    .redir_alu(redir_alu), .redir_zero(redir_zero),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .err_src(err_src)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  bit          gnt_en, rv_en, rv_pend, no_pop;
  logic [31:0] rv_addr;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: respond as imem and monitor decode at negedge, return 1 after posedge.
  task automatic cyc();
    logic [31:0] e;
    @(negedge clk);
    imem_rvalid = rv_pend && rv_en;
    imem_rdata  = imem_rvalid ? mem_word(rv_addr) : 32'h0;
    if (imem_rvalid) rv_pend = 1'b0;
    imem_gnt = imem_req && gnt_en;
    if (imem_gnt) begin
      rv_pend = 1'b1;
      rv_addr = imem_addr;
      got_q.push_back(imem_addr);
    end
    if (if_valid && if_ready && !no_pop) begin
      if (exp_q.size() == 0) chk("extra_out", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("if_pc", if_pc, e);
        chk("if_instr", if_instr, mem_word(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_empty(int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc();
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_valid(int budget);
    int n = 0;
    while (!if_valid && n < budget) begin
      cyc();
      n++;
    end
    chk("valid_timeout", {31'd0, if_valid}, 32'd1);
  endtask

  task automatic chk_addr(logic [31:0] e);
    logic [31:0] a;
    if (got_q.size() == 0) chk("gnt_addr_missing", 32'(got_q.size()), 32'd1);
    else begin
      a = got_q.pop_front();
      chk("gnt_addr", a, e);
    end
  endtask

  task automatic redir(logic [2:0] src, logic [31:0] tar, logic [31:0] alu, logic z);
    redir_valid = 1'b1;
    redir_src   = src;
    redir_tar   = tar;
    redir_alu   = alu;
    redir_zero  = z;
    cyc();
    redir_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    redir_valid = 1'b0; redir_src = 3'b000; redir_tar = '0; redir_alu = '0; redir_zero = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b1;
    gnt_en = 1'b1; rv_en = 1'b1; rv_pend = 1'b0; no_pop = 1'b0; rv_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_err", {31'd0, err_src}, 32'd0);
    rst = 1'b1;

    // T1: back-to-back sequential fetch
    exp_q.push_back(32'h1000); exp_q.push_back(32'h1004); exp_q.push_back(32'h1008);
    run_until_empty(40);
    gnt_en = 1'b0;
    chk_addr(32'h1000); chk_addr(32'h1004); chk_addr(32'h1008);

    // T2: decode back-pressure holds the buffered instruction
    gnt_en = 1'b1; if_ready = 1'b0;
    wait_valid(20);
    repeat (5) begin
      cyc();
      chk("hold_valid", {31'd0, if_valid}, 32'd1);
      chk("hold_pc", if_pc, 32'h100C);
      chk("hold_instr", if_instr, mem_word(32'h100C));
      chk("hold_noreq", {31'd0, imem_req}, 32'd0);
    end
    gnt_en = 1'b0; if_ready = 1'b1;
    exp_q.push_back(32'h100C);
    cyc();
    chk_addr(32'h100C);

    // T3: redirect while waiting; in-flight data must be dropped
    rv_en = 1'b0; gnt_en = 1'b1;
    cyc();
    redir(3'b011, 32'h2000, 32'h0, 1'b0);
    rv_en = 1'b1;
    exp_q.push_back(32'h2000);
    run_until_empty(30);
    gnt_en = 1'b0;
    chk_addr(32'h1010); chk_addr(32'h2000);

    // T4: branch encodings applied while parked in REQ
    redir(3'b001, 32'h3000, 32'h0, 1'b0);
    exp_q.push_back(32'h2004); gnt_en = 1'b1; run_until_empty(30); gnt_en = 1'b0;
    chk_addr(32'h2004);
    redir(3'b010, 32'h3000, 32'h0, 1'b0);
    exp_q.push_back(32'h3000); gnt_en = 1'b1; run_until_empty(30); gnt_en = 1'b0;
    chk_addr(32'h3000);
    redir(3'b100, 32'h5000, 32'h40, 1'b0);
    exp_q.push_back(32'h40); gnt_en = 1'b1; run_until_empty(30); gnt_en = 1'b0;
    chk_addr(32'h40);
    // redirect in the same cycle as a grant: the granted fetch becomes stale
    gnt_en = 1'b1;
    redir(3'b001, 32'h4000, 32'h0, 1'b1);
    exp_q.push_back(32'h4000); run_until_empty(30); gnt_en = 1'b0;
    chk_addr(32'h44); chk_addr(32'h4000);

    // T5: illegal source is sticky and does not redirect
    chk("err_before", {31'd0, err_src}, 32'd0);
    redir(3'b110, 32'h6000, 32'h0, 1'b0);
    chk("err_set", {31'd0, err_src}, 32'd1);
    exp_q.push_back(32'h4004); exp_q.push_back(32'h4008);
    gnt_en = 1'b1; run_until_empty(40); gnt_en = 1'b0;
    chk("err_sticky", {31'd0, err_src}, 32'd1);
    chk_addr(32'h4004); chk_addr(32'h4008);

    // T6: async reset mid-WAIT
    rv_en = 1'b0; gnt_en = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_valid", {31'd0, if_valid}, 32'd0);
    chk("arst_instr", if_instr, 32'd0);
    chk("arst_pc", if_pc, 32'd0);
    chk("arst_err", {31'd0, err_src}, 32'd0);
    rv_pend = 1'b0; rv_en = 1'b1;
    cyc();
    rst = 1'b1;
    exp_q.push_back(32'h1000); run_until_empty(30); gnt_en = 1'b0;
    chk_addr(32'h400C); chk_addr(32'h1000);

    // T7: PC wrap
    redir(3'b011, 32'hFFFF_FFFC, 32'h0, 1'b0);
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    gnt_en = 1'b1; run_until_empty(40); gnt_en = 1'b0;
    chk_addr(32'hFFFF_FFFC); chk_addr(32'h0);

    // redirect in HOLD flushes the buffer even with if_ready high
    gnt_en = 1'b1; if_ready = 1'b0;
    wait_valid(20);
    chk("flush_pc_before", if_pc, 32'h4);
    if_ready = 1'b1; no_pop = 1'b1;
    redir(3'b011, 32'h7000, 32'h0, 1'b0);
    no_pop = 1'b0;
    chk("flush_valid", {31'd0, if_valid}, 32'd0);
    exp_q.push_back(32'h7000); run_until_empty(30); gnt_en = 1'b0;
    chk_addr(32'h4); chk_addr(32'h7000);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("gnt_q_empty", 32'(got_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
